control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 116 +++++++++++
 tb/tb_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit: IDLE/FETCH/EXEC/HALT sequencer that latches an
// instruction word and decodes it into register strobes, bus-source select and ALU op.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Z,
  input  logic [15:0] instruction,
  input  logic [1:0]  status,
  output logic        finish,
  output logic [16:0] write_enable,
  output logic [4:0]  read_enable,
  output logic [6:0]  increment,
  output logic [2:0]  alu
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state, state_next;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [4:0]  dst;
  logic [4:0]  src;
  logic        unused_ir_bits;

  assign opcode         = ir[15:12];
  assign dst            = ir[11:7];
  assign src            = ir[6:2];
  assign unused_ir_bits = ^ir[1:0];

  // Out-of-range destinations decode to no strobe rather than wrapping.
  function automatic logic [16:0] write_onehot(input logic [4:0] d);
    return (d < 5'd17) ? (17'd1 << d) : 17'd0;
  endfunction

  function automatic logic [6:0] inc_onehot(input logic [4:0] d);
    return (d < 5'd7) ? (7'd1 << d[2:0]) : 7'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= 16'd0;
    end else begin
      state <= state_next;
      if (state == FETCH && status[0])
        ir <= instruction;
    end
  end

  always_comb begin
    state_next   = state;
    finish       = 1'b0;
    write_enable = 17'd0;
    read_enable  = 5'd0;
    increment    = 7'd0;
    alu          = 3'd0;
    case (state)
      IDLE: begin
        if (status[1])
          state_next = FETCH;
      end
      FETCH: begin
        if (status[0]) begin
          increment  = 7'd1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = FETCH;
        case (opcode)
          4'd0: ;
          4'd1: begin
            read_enable  = src;
            write_enable = write_onehot(dst);
          end
          4'd2: increment = inc_onehot(dst);
          4'd3: begin
            // Load waits here until memory reports ready.
            read_enable = src;
            if (status[0])
              write_enable = write_onehot(dst);
            else
              state_next = EXEC;
          end
          4'd4: begin
            read_enable  = src;
            write_enable = 17'd1;
          end
          4'd5: begin
            if (Z) begin
              read_enable  = src;
              write_enable = 17'd1;
            end
          end
          4'd6: begin
            if (!Z) begin
              read_enable  = src;
              write_enable = 17'd1;
            end
          end
          4'd7: state_next = HALT;
          default: begin
            alu          = opcode[2:0];
            read_enable  = src;
            write_enable = 17'h10000;
          end
        endcase
      end
      HALT: begin
        finish = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with hand-computed expected strobes.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        Z;
  logic [15:0] instruction;
  logic [1:0]  status;
  logic        finish;
  logic [16:0] write_enable;
  logic [4:0]  read_enable;
  logic [6:0]  increment;
  logic [2:0]  alu;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Z            (Z),
    .instruction  (instruction),
    .status       (status),
    .finish       (finish),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .increment    (increment),
    .alu          (alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic f, input logic [16:0] we,
                          input logic [4:0] re, input logic [6:0] inc, input logic [2:0] op);
    checkOutput({tag, ".finish"}, 32'(finish), 32'(f));
    checkOutput({tag, ".we"}, 32'(write_enable), 32'(we));
    checkOutput({tag, ".re"}, 32'(read_enable), 32'(re));
    checkOutput({tag, ".inc"}, 32'(increment), 32'(inc));
    checkOutput({tag, ".alu"}, 32'(alu), 32'(op));
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic [15:0] instr, input logic z);
    status      = st;
    instruction = instr;
    Z           = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs from IDLE through FETCH, leaving the unit in EXEC with instr latched.
  task automatic fetchFromIdle(input string tag, input logic [15:0] instr, input logic z);
    applyStimulus(2'b10, 16'h0000, z);
    tick();
    applyStimulus(2'b11, instr, z);
    checkAll({tag, ".fetch"}, 1'b0, 17'd0, 5'd0, 7'h01, 3'd0);
    tick();
  endtask

  // From FETCH, latch instr and move to EXEC.
  task automatic fetch(input string tag, input logic [15:0] instr, input logic z);
    applyStimulus(2'b11, instr, z);
    checkAll({tag, ".fetch"}, 1'b0, 17'd0, 5'd0, 7'h01, 3'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b11, 16'h128C, 1'b1);
    #13;
    checkAll("in_reset", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    applyStimulus(2'b00, 16'h128C, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("idle_hold", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    end
    applyStimulus(2'b01, 16'h128C, 1'b0);
    checkAll("idle_ready_only", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);

    // MOV r5 <- src 3
    fetchFromIdle("mov", 16'h128C, 1'b0);
    applyStimulus(2'b00, 16'hFFFF, 1'b0);
    checkAll("mov.exec", 1'b0, 17'h00020, 5'd3, 7'd0, 3'd0);
    tick();

    applyStimulus(2'b00, 16'h5010, 1'b0);
    checkAll("fetch_wait", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    tick();
    fetch("jz0", 16'h5010, 1'b0);
    checkAll("jz0.exec", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    tick();
    fetch("jz1", 16'h5010, 1'b1);
    checkAll("jz1.exec", 1'b0, 17'h00001, 5'd4, 7'd0, 3'd0);
    tick();
    fetch("jnz0", 16'h6010, 1'b0);
    checkAll("jnz0.exec", 1'b0, 17'h00001, 5'd4, 7'd0, 3'd0);
    tick();
    fetch("jnz1", 16'h6010, 1'b1);
    checkAll("jnz1.exec", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    tick();

    fetch("alu", 16'hA008, 1'b0);
    checkAll("alu.exec", 1'b0, 17'h10000, 5'd2, 7'd0, 3'b010);
    tick();
    fetch("inc", 16'h2180, 1'b0);
    checkAll("inc.exec", 1'b0, 17'd0, 5'd0, 7'h08, 3'd0);
    tick();
    fetch("mov_oob", 16'h1F84, 1'b0);
    checkAll("mov_oob.exec", 1'b0, 17'd0, 5'd1, 7'd0, 3'd0);
    tick();
    fetch("inc_oob", 16'h2400, 1'b0);
    checkAll("inc_oob.exec", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    tick();

    // LDW r1 <- src 5, interrupted by reset while waiting
    fetch("ldw_a", 16'h3094, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b0);
    checkAll("ldw_a.wait0", 1'b0, 17'd0, 5'd5, 7'd0, 3'd0);
    tick();
    checkAll("ldw_a.wait1", 1'b0, 17'd0, 5'd5, 7'd0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("ldw_reset", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(2'b01, 16'h3094, 1'b0);
    checkAll("ldw_reset.idle", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);

    fetchFromIdle("ldw_b", 16'h3094, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b0);
    checkAll("ldw_b.wait", 1'b0, 17'd0, 5'd5, 7'd0, 3'd0);
    tick();
    applyStimulus(2'b01, 16'h0000, 1'b0);
    checkAll("ldw_b.done", 1'b0, 17'h00002, 5'd5, 7'd0, 3'd0);
    tick();

    fetch("halt", 16'h7000, 1'b0);
    checkAll("halt.exec", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'($urandom), 16'($urandom), 1'($urandom));
      checkAll("halt_hold", 1'b1, 17'd0, 5'd0, 7'd0, 3'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkAll("halt_reset", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(2'b01, 16'h0000, 1'b0);
    checkAll("halt_reset.idle", 1'b0, 17'd0, 5'd0, 7'd0, 3'd0);
    fetchFromIdle("restart", 16'h128C, 1'b0);
    checkAll("restart.exec", 1'b0, 17'h00020, 5'd3, 7'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
